// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch requester (if_*)
// and a load/store requester (ls_*). One transaction is outstanding at a time.
// Load/store wins arbitration by default. Defining ARB_STARVE_GUARD_EN adds a
// 4-bit starvation counter that hands the port to fetch once it has lost
// MAX_WAIT arbitrations in a row. A flush discards the response of the
// fetch in flight without aborting the bus transaction.
//
// Handshake: mem_req is offered combinationally from IDLE; the transaction
// is accepted in the cycle where mem_req and mem_ready are both high, which
// is also the single cycle in which the winner's gnt pulses. The response
// arrives later as a one-cycle mem_rvalid with mem_rdata, while the FSM sits
// in the matching BUSY state; mem_rvalid seen in IDLE is ignored.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    // fetch requester
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    // load/store requester
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    // pipeline flush
    input  logic          flush,
    // shared memory port
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    // debug: current FSM state (0 IDLE, 1 BUSY_IF, 2 BUSY_LS)
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_LS = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_drop_q;
    logic   w_drop_nxt;
    logic   w_starved;
    logic   w_if_wins;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0] r_starve_cnt;

    assign w_starved = (r_starve_cnt >= LP_MAX_WAIT);

    // Count arbitrations fetch has lost while still requesting; saturate at 15,
    // restart once fetch is granted or stops asking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (!if_req || if_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (ls_gnt && (r_starve_cnt != 4'd15)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`else
    // Without the guard the wait limit has no effect on arbitration.
    logic [3:0] w_unused_max_wait;
    assign w_unused_max_wait = 4'(MAX_WAIT);
    assign w_starved         = 1'b0;
`endif

    assign w_if_wins = if_req && (!ls_req || w_starved);

    // State register and fetch-drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_drop_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_drop_q <= w_drop_nxt;
        end
    end

    // Next state, arbitration and memory request outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // rst gates the request so nothing leaks out while held in reset
                if (!rst && (if_req || ls_req)) begin
                    mem_req = 1'b1;
                    if (w_if_wins) begin
                        mem_addr = if_addr;
                        if (mem_ready) begin
                            if_gnt      = 1'b1;
                            w_state_nxt = ST_BUSY_IF;
                            // a flush coinciding with the grant already kills the response
                            w_drop_nxt  = flush;
                        end
                    end else begin
                        mem_we    = ls_we;
                        mem_addr  = ls_addr;
                        mem_wdata = ls_wdata;
                        if (mem_ready) begin
                            ls_gnt      = 1'b1;
                            w_state_nxt = ST_BUSY_LS;
                        end
                    end
                end
            end
            ST_BUSY_IF: begin
                if (mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_drop_nxt = r_drop_q | flush;
                end
            end
            ST_BUSY_LS: begin
                if (mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign if_rvalid   = (r_state == ST_BUSY_IF) && mem_rvalid && !r_drop_q && !flush;
    assign ls_rvalid   = (r_state == ST_BUSY_LS) && mem_rvalid;
    assign if_rdata    = mem_rdata;
    assign ls_rdata    = mem_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, ls/if priority
// (with or without ARB_STARVE_GUARD_EN), fetch flush, ls flush immunity,
// mem_ready stall and reset in mid-transaction.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BIF  = 2'd1;
    localparam logic [1:0] S_BLS  = 2'd2;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          flush;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    o_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_quiet();
        if_req     = 1'b0;
        if_addr    = '0;
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        ls_addr    = '0;
        ls_wdata   = '0;
        flush      = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic test_reset();
        drive_quiet();
        rst        = 1'b1;
        if_req     = 1'b1;
        ls_req     = 1'b1;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        next_cycle();
        #1;
        n_tests++;
        if ({mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: req/ignt/lgnt/irv/lrv got %b want 00000",
                     {mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid});
        end
        n_tests++;
        if (o_dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", o_dbg_state, S_IDLE);
        end
        next_cycle();
        rst = 1'b0;
        drive_quiet();
    endtask

    task automatic test_fetch();
        next_cycle();
        if_req    = 1'b1;
        if_addr   = 32'h40;
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if ({mem_req, if_gnt, ls_gnt, mem_we} !== 4'b1100 || mem_addr !== 32'h40 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL fetch_grant: req/ignt/lgnt/we=%b addr=%h wdata=%h want 1100 40 0",
                     {mem_req, if_gnt, ls_gnt, mem_we}, mem_addr, mem_wdata);
        end
        next_cycle();
        if_req = 1'b0;
        #1;
        n_tests++;
        if (o_dbg_state !== S_BIF || mem_req !== 1'b0 || if_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_busy: state=%0d req=%b irv=%b want 1 0 0", o_dbg_state, mem_req, if_rvalid);
        end
        next_cycle();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h13;
        #1;
        n_tests++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h13 || ls_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_resp: irv=%b idata=%h lrv=%b want 1 13 0", if_rvalid, if_rdata, ls_rvalid);
        end
        next_cycle();
        drive_quiet();
        #1;
        n_tests++;
        if (o_dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL fetch_done: state=%0d want 0", o_dbg_state);
        end
    endtask

    task automatic test_priority();
        logic exp_if;
        next_cycle();
        if_req    = 1'b1;
        if_addr   = 32'h80;
        ls_req    = 1'b1;
        ls_we     = 1'b1;
        ls_addr   = 32'h200;
        ls_wdata  = 32'hCAFE;
        mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_if = (k == 4);
`else
            exp_if = 1'b0;
`endif
            #1;
            n_tests++;
            if (if_gnt !== exp_if || ls_gnt !== !exp_if || mem_req !== 1'b1) begin
                n_fail++;
                $display("FAIL prio_gnt[%0d]: ignt=%b lgnt=%b req=%b want %b %b 1",
                         k, if_gnt, ls_gnt, mem_req, exp_if, !exp_if);
            end
            n_tests++;
            if (mem_we !== !exp_if || mem_addr !== (exp_if ? 32'h80 : 32'h200) ||
                mem_wdata !== (exp_if ? 32'h0 : 32'hCAFE)) begin
                n_fail++;
                $display("FAIL prio_fields[%0d]: we=%b addr=%h wdata=%h", k, mem_we, mem_addr, mem_wdata);
            end
            next_cycle();
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h100 + 32'(k);
            #1;
            n_tests++;
            if (ls_rvalid !== !exp_if || if_rvalid !== exp_if || mem_req !== 1'b0 ||
                ls_rdata !== 32'h100 + 32'(k)) begin
                n_fail++;
                $display("FAIL prio_resp[%0d]: lrv=%b irv=%b req=%b ldata=%h", k, ls_rvalid, if_rvalid,
                         mem_req, ls_rdata);
            end
            next_cycle();
            mem_rvalid = 1'b0;
        end
        drive_quiet();
        next_cycle();
    endtask

    task automatic test_flush();
        next_cycle();
        if_req    = 1'b1;
        if_addr   = 32'h44;
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if (if_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_grant: ignt=%b want 1", if_gnt);
        end
        next_cycle();
        if_req = 1'b0;
        flush  = 1'b1;
        next_cycle();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_tests++;
            if (o_dbg_state !== S_BIF) begin
                n_fail++;
                $display("FAIL flush_wait[%0d]: state=%0d want 1", k, o_dbg_state);
            end
            next_cycle();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD;
        #1;
        n_tests++;
        if (if_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: irv=%b want 0", if_rvalid);
        end
        next_cycle();
        mem_rvalid = 1'b0;
        if_req     = 1'b1;
        if_addr    = 32'h48;
        #1;
        n_tests++;
        if (o_dbg_state !== S_IDLE || if_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_regrant: state=%0d ignt=%b want 0 1", o_dbg_state, if_gnt);
        end
        next_cycle();
        if_req     = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55;
        #1;
        n_tests++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h55) begin
            n_fail++;
            $display("FAIL flush_next_resp: irv=%b idata=%h want 1 55", if_rvalid, if_rdata);
        end
        next_cycle();
        drive_quiet();
    endtask

    task automatic test_flush_ls();
        next_cycle();
        ls_req    = 1'b1;
        ls_addr   = 32'h300;
        mem_ready = 1'b1;
        flush     = 1'b1;
        #1;
        n_tests++;
        if (ls_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ls_gnt: lgnt=%b want 1", ls_gnt);
        end
        next_cycle();
        ls_req     = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77;
        #1;
        n_tests++;
        if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h77) begin
            n_fail++;
            $display("FAIL flush_ls_resp: lrv=%b ldata=%h want 1 77", ls_rvalid, ls_rdata);
        end
        next_cycle();
        drive_quiet();
    endtask

    task automatic test_ready_stall();
        next_cycle();
        if_req  = 1'b1;
        if_addr = 32'h10;
        ls_req  = 1'b1;
        ls_addr = 32'h20;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++;
            if (if_gnt !== 1'b0 || ls_gnt !== 1'b0 || mem_req !== 1'b1 || o_dbg_state !== S_IDLE) begin
                n_fail++;
                $display("FAIL stall[%0d]: ignt=%b lgnt=%b req=%b state=%0d want 0 0 1 0",
                         k, if_gnt, ls_gnt, mem_req, o_dbg_state);
            end
            next_cycle();
        end
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if (ls_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h20) begin
            n_fail++;
            $display("FAIL stall_release: lgnt=%b ignt=%b addr=%h want 1 0 20", ls_gnt, if_gnt, mem_addr);
        end
        next_cycle();
        drive_quiet();
        mem_rvalid = 1'b1;
        next_cycle();
        drive_quiet();
    endtask

    task automatic test_reset_mid();
        next_cycle();
        ls_req    = 1'b1;
        ls_addr   = 32'h400;
        mem_ready = 1'b1;
        next_cycle();
        ls_req = 1'b0;
        #1;
        n_tests++;
        if (o_dbg_state !== S_BLS) begin
            n_fail++;
            $display("FAIL rstmid_busy: state=%0d want 2", o_dbg_state);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (o_dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL rstmid_async: state=%0d want 0", o_dbg_state);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h99;
        #1;
        n_tests++;
        if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0 || o_dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL rstmid_late: lrv=%b irv=%b state=%0d want 0 0 0", ls_rvalid, if_rvalid, o_dbg_state);
        end
        next_cycle();
        drive_quiet();
        #1;
        n_tests++;
        if (o_dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL rstmid_idle: state=%0d want 0", o_dbg_state);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_quiet();
        test_reset();
        test_fetch();
        test_priority();
        test_flush();
        test_flush_ls();
        test_ready_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
